// File: rtl/answer_checker.sv
// Quiz answer checker: synchronizes the button buffer outputs, scores each captured
// choice against a packed answer key and handshakes the buffer clear between questions.
module answer_checker #(
    parameter int              NQ      = 8,
    parameter int              IDX_W   = 3,
    parameter int              SCORE_W = 4,
    parameter int              TO_W    = 24,
    parameter logic [TO_W-1:0] TIMEOUT = 24'd10000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s0,
    input  logic               s1,
    input  logic               press,
    input  logic               start,
    input  logic [2*NQ-1:0]    key,
    output logic               buf_clear,
    output logic [IDX_W-1:0]   q_index,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         last_choice,
    output logic               last_ok,
    output logic               last_timeout,
    output logic               answer_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        CAPTURE,
        CLEAR,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0]   LAST_Q    = IDX_W'(NQ - 1);
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(NQ);
    localparam logic [TO_W-1:0]    TO_LAST   = TIMEOUT - 1'b1;

    // Two-flop synchronizers; bit order {press, s1, s0}
    logic [2:0] raw_in;
    logic [2:0] sync1_reg;
    logic [2:0] sync2_reg;
    logic       s0_q;
    logic       s1_q;
    logic       press_q;

    assign raw_in = {press, s1, s0};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= raw_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    assign s0_q    = sync2_reg[0];
    assign s1_q    = sync2_reg[1];
    assign press_q = sync2_reg[2];

    // Unpack the key so the current question's answer is a plain array lookup
    logic [1:0] key_arr [NQ];

    generate
        for (genvar gi = 0; gi < NQ; gi++) begin : g_key
            assign key_arr[gi] = key[2*gi +: 2];
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   q_index_reg, q_index_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [1:0]         last_choice_reg, last_choice_next;
    logic               last_ok_reg, last_ok_next;
    logic               last_timeout_reg, last_timeout_next;
    logic               answer_valid_reg, answer_valid_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               buf_clear_reg, buf_clear_next;
    logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
    logic [1:0]         choice_reg, choice_next;
    logic               timed_out_reg, timed_out_next;
    logic               match;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= IDLE;
            q_index_reg      <= '0;
            score_reg        <= '0;
            last_choice_reg  <= 2'b00;
            last_ok_reg      <= 1'b0;
            last_timeout_reg <= 1'b0;
            answer_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            buf_clear_reg    <= 1'b1;
            to_cnt_reg       <= '0;
            choice_reg       <= 2'b00;
            timed_out_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            q_index_reg      <= q_index_next;
            score_reg        <= score_next;
            last_choice_reg  <= last_choice_next;
            last_ok_reg      <= last_ok_next;
            last_timeout_reg <= last_timeout_next;
            answer_valid_reg <= answer_valid_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
            buf_clear_reg    <= buf_clear_next;
            to_cnt_reg       <= to_cnt_next;
            choice_reg       <= choice_next;
            timed_out_reg    <= timed_out_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        q_index_next      = q_index_reg;
        score_next        = score_reg;
        last_choice_next  = last_choice_reg;
        last_ok_next      = last_ok_reg;
        last_timeout_next = last_timeout_reg;
        answer_valid_next = 1'b0;
        to_cnt_next       = to_cnt_reg;
        choice_next       = choice_reg;
        timed_out_next    = timed_out_reg;
        match             = (choice_reg == key_arr[q_index_reg]);

        unique case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    q_index_next      = '0;
                    score_next        = '0;
                    last_choice_next  = 2'b00;
                    last_ok_next      = 1'b0;
                    last_timeout_next = 1'b0;
                    to_cnt_next       = '0;
                    state_next        = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                to_cnt_next = to_cnt_reg + 1'b1;
                // A press in the expiry cycle still counts as an answer
                if (press_q) begin
                    choice_next    = {s1_q, s0_q};
                    timed_out_next = 1'b0;
                    state_next     = CAPTURE;
                end else if ((TIMEOUT != '0) && (to_cnt_reg == TO_LAST)) begin
                    choice_next    = 2'b00;
                    timed_out_next = 1'b1;
                    state_next     = CAPTURE;
                end
            end
            CAPTURE: begin
                answer_valid_next = 1'b1;
                if (timed_out_reg) begin
                    last_choice_next  = 2'b00;
                    last_ok_next      = 1'b0;
                    last_timeout_next = 1'b1;
                end else begin
                    last_choice_next  = choice_reg;
                    last_ok_next      = match;
                    last_timeout_next = 1'b0;
                    if (match && (score_reg < MAX_SCORE)) begin
                        score_next = score_reg + 1'b1;
                    end
                end
                state_next = CLEAR;
            end
            CLEAR: begin
                // Hold the clear until the button is released and the buffer empties
                if (!press_q) begin
                    if (q_index_reg == LAST_Q) begin
                        state_next = DONE;
                    end else begin
                        q_index_next = q_index_reg + 1'b1;
                        to_cnt_next  = '0;
                        state_next   = WAIT_PRESS;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next      = (state_next == WAIT_PRESS) || (state_next == CAPTURE) ||
                         (state_next == CLEAR);
        done_next      = (state_next == DONE);
        buf_clear_next = (state_next == IDLE) || (state_next == CLEAR) ||
                         (state_next == DONE);
    end

    assign buf_clear    = buf_clear_reg;
    assign q_index      = q_index_reg;
    assign score        = score_reg;
    assign last_choice  = last_choice_reg;
    assign last_ok      = last_ok_reg;
    assign last_timeout = last_timeout_reg;
    assign answer_valid = answer_valid_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_answer_checker.sv
// Directed bench for answer_checker with a 4-question round and a 16-cycle timeout;
// expected values are worked out by hand from the key 11_10_01_00.
module tb_answer_checker;

    localparam int NQ      = 4;
    localparam int IDX_W   = 2;
    localparam int SCORE_W = 3;
    localparam int TO_W    = 24;

    logic               clk = 1'b0;
    logic               reset;
    logic               s0, s1, press, start;
    logic [2*NQ-1:0]    key;
    logic               buf_clear;
    logic [IDX_W-1:0]   q_index;
    logic [SCORE_W-1:0] score;
    logic [1:0]         last_choice;
    logic               last_ok, last_timeout, answer_valid, busy, done;

    int checks = 0;
    int passes = 0;

    answer_checker #(
        .NQ(NQ), .IDX_W(IDX_W), .SCORE_W(SCORE_W), .TO_W(TO_W), .TIMEOUT(24'd16)
    ) dut (
        .clk(clk), .reset(reset), .s0(s0), .s1(s1), .press(press), .start(start),
        .key(key), .buf_clear(buf_clear), .q_index(q_index), .score(score),
        .last_choice(last_choice), .last_ok(last_ok), .last_timeout(last_timeout),
        .answer_valid(answer_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Press a choice, wait for the scored pulse, optionally keep holding, then release
    task automatic answer(input logic [1:0] ch, input logic exp_ok, input int exp_score,
                          input int exp_q, input int hold);
        int n;
        n = 0;
        s1 = ch[1];
        s0 = ch[0];
        press = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (answer_valid) begin
                n = i;
                break;
            end
        end
        check("press_latency", n, 4);
        check("last_choice", last_choice, ch);
        check("last_ok", last_ok, exp_ok);
        check("last_timeout", last_timeout, 0);
        check("score", score, exp_score);
        check("q_at_answer", q_index, exp_q);
        @(negedge clk);
        check("valid_one_cycle", answer_valid, 0);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check("held_buf_clear", buf_clear, 1);
            check("held_q_index", q_index, exp_q);
        end
        press = 1'b0;
        repeat (4) @(negedge clk);
        if (exp_q < NQ - 1) begin
            check("q_advance", q_index, exp_q + 1);
            check("wait_buf_clear", buf_clear, 0);
        end else begin
            check("done_after_last", done, 1);
            check("busy_after_last", busy, 0);
        end
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        s0 = 1'b0;
        s1 = 1'b0;
        press = 1'b0;
        key = 8'b11_10_01_00;
        repeat (3) @(negedge clk);
        check("rst_q_index", q_index, 0);
        check("rst_score", score, 0);
        check("rst_buf_clear", buf_clear, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", answer_valid, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Round 1: every answer correct
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_buf_clear", buf_clear, 0);
        answer(2'b00, 1'b1, 1, 0, 0);
        answer(2'b01, 1'b1, 2, 1, 0);
        answer(2'b10, 1'b1, 3, 2, 0);
        answer(2'b11, 1'b1, 4, 3, 0);
        check("r1_final_score", score, 4);
        check("r1_final_q", q_index, 3);

        // Round 2 restarted from DONE: mixed answers
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_done", done, 0);
        check("restart_score", score, 0);
        answer(2'b11, 1'b0, 0, 0, 0);
        answer(2'b01, 1'b1, 1, 1, 0);
        answer(2'b00, 1'b0, 1, 2, 0);
        answer(2'b11, 1'b1, 2, 3, 0);
        check("r2_final_score", score, 2);

        // Round 3: no press on question 0 times out
        start = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (answer_valid) begin
                n = i;
                break;
            end
        end
        check("timeout_latency", n, 18);
        check("to_last_timeout", last_timeout, 1);
        check("to_last_ok", last_ok, 0);
        check("to_last_choice", last_choice, 0);
        check("to_score", score, 0);
        @(negedge clk);
        check("to_q_advance", q_index, 1);
        check("to_buf_clear", buf_clear, 0);

        // Button held long after capture on question 1
        answer(2'b01, 1'b1, 1, 1, 20);

        // Reset mid-round at q_index=2, score=1
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_q", q_index, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_buf_clear", buf_clear, 1);
        check("mid_rst_valid", answer_valid, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        check("idle_stays", busy, 0);

        // Round 4: finish with score 3, then restart and try start mid-question
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        answer(2'b00, 1'b1, 1, 0, 0);
        answer(2'b01, 1'b1, 2, 1, 0);
        answer(2'b10, 1'b1, 3, 2, 0);
        answer(2'b00, 1'b0, 3, 3, 0);
        check("done_score3", score, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rs_q", q_index, 0);
        check("rs_score", score, 0);
        check("rs_done", done, 0);
        check("rs_busy", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("wait_start_busy", busy, 1);
        check("wait_start_q", q_index, 0);
        check("wait_start_clear", buf_clear, 0);
        answer(2'b00, 1'b1, 1, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
